// File: rtl/division_controller.sv
// Sequencer for a restoring divider: steps the A/Q/M datapath through N
// shift/subtract/test iterations and reports busy/done/div_by_zero to the host.
module division_controller #(
  parameter int N  = 16,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  divisor,
  input  logic          a_msb,
  output logic          load_enable,
  output logic          shift_left_enable_a,
  output logic          shift_left_enable_q,
  output logic          sub_enable,
  output logic          restore_enable,
  output logic          q0_write,
  output logic          q0_value,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero,
  output logic [CW-1:0] iter_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SUB,
    ST_TEST,
    ST_DONE
  } state_e;

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          dbz_q, dbz_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the asynchronous reset forces IDLE, which zeroes all
  // Moore outputs without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      dbz_q   <= dbz_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    dbz_d   = dbz_q;
    if (abort) begin
      // Also covers IDLE: abort beats a simultaneous start.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state_d = ST_DONE;
              dbz_d   = 1'b1;
            end else begin
              state_d = ST_LOAD;
              dbz_d   = 1'b0;
            end
          end
        end
        ST_LOAD: begin
          iter_d  = '0;
          state_d = ST_SHIFT;
        end
        ST_SHIFT: state_d = ST_SUB;
        ST_SUB:   state_d = ST_TEST;
        ST_TEST: begin
          if (iter_q == LAST_ITER) begin
            state_d = ST_DONE;
          end else begin
            iter_d  = iter_q + CW'(1);
            state_d = ST_SHIFT;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load_enable         = 1'b0;
    shift_left_enable_a = 1'b0;
    shift_left_enable_q = 1'b0;
    sub_enable          = 1'b0;
    restore_enable      = 1'b0;
    q0_write            = 1'b0;
    q0_value            = 1'b0;
    busy                = 1'b0;
    done                = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_enable = 1'b1;
        busy        = 1'b1;
      end
      ST_SHIFT: begin
        shift_left_enable_a = 1'b1;
        shift_left_enable_q = 1'b1;
        busy                = 1'b1;
      end
      ST_SUB: begin
        sub_enable = 1'b1;
        busy       = 1'b1;
      end
      ST_TEST: begin
        // Negative partial remainder: undo the subtract and record a 0 bit.
        q0_write       = 1'b1;
        restore_enable = a_msb;
        q0_value       = ~a_msb;
        busy           = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign iter_count  = iter_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_division_controller.sv
// Self-checking bench: drives the controller with a behavioural A/Q/M datapath
// and compares quotient/remainder, timing and strobe counts against arithmetic.
module tb_division_controller;

  localparam int N      = 16;
  localparam int CW     = $clog2(N);
  localparam int DONE_C = 3 * N + 2;
  localparam int LAST_C = 3 * N + 4;

  logic          clk, rst, start, abort, a_msb;
  logic [N-1:0]  divisor, dividend;
  logic          load_enable, shift_left_enable_a, shift_left_enable_q, sub_enable;
  logic          restore_enable, q0_write, q0_value, busy, done, div_by_zero;
  logic [CW-1:0] iter_count;

  division_controller #(.N(N), .CW(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
    .divisor             (divisor),
    .a_msb               (a_msb),
    .load_enable         (load_enable),
    .shift_left_enable_a (shift_left_enable_a),
    .shift_left_enable_q (shift_left_enable_q),
    .sub_enable          (sub_enable),
    .restore_enable      (restore_enable),
    .q0_write            (q0_write),
    .q0_value            (q0_value),
    .busy                (busy),
    .done                (done),
    .div_by_zero         (div_by_zero),
    .iter_count          (iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural datapath obeying the strobes.
  logic [N:0]   dp_a;
  logic [N-1:0] dp_q, dp_m;
  assign a_msb = dp_a[N];

  always @(posedge clk) begin
    if (load_enable) begin
      dp_a <= '0;
      dp_q <= dividend;
      dp_m <= divisor;
    end else begin
      if (shift_left_enable_a) dp_a <= {dp_a[N-1:0], dp_q[N-1]};
      if (shift_left_enable_q) dp_q <= {dp_q[N-2:0], 1'b0};
      if (sub_enable)          dp_a <= dp_a - {1'b0, dp_m};
      if (restore_enable)      dp_a <= dp_a + {1'b0, dp_m};
      if (q0_write)            dp_q[0] <= q0_value;
    end
  end

  // Per-cycle invariants.
  always @(negedge clk) begin
    if (rst) begin
      check("strobe_onehot",
            32'(($countones({load_enable, shift_left_enable_a, sub_enable, q0_write}) <= 1)
                && (shift_left_enable_a == shift_left_enable_q)
                && (!restore_enable || q0_write)), 32'd1);
      check("done_and_busy", 32'(done & busy), 32'd0);
      check("iter_range", 32'(int'(iter_count) <= N - 1), 32'd1);
    end
  end

  int           done_first, done_cnt, busy_cnt, busy_first, busy_last;
  int           q0w_cnt, ones_cnt, restore_cnt, load_cnt, last_load, dp_strobe_cnt;
  logic         dbz_c1;
  logic [N-1:0] q_bits;
  logic [8:0]   snap_after_abort;

  function automatic logic [8:0] out_vec();
    return {load_enable, shift_left_enable_a, shift_left_enable_q, sub_enable,
            restore_enable, q0_write, q0_value, busy, done};
  endfunction

  // Called at a negedge while in IDLE; returns at the negedge of cycle LAST_C+1.
  task automatic run_op(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                        input int abort_cyc, input bit hold);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    done_first = -1; done_cnt = 0; busy_cnt = 0; busy_first = -1; busy_last = -1;
    q0w_cnt = 0; ones_cnt = 0; restore_cnt = 0; load_cnt = 0; last_load = -1;
    dp_strobe_cnt = 0; q_bits = '0; snap_after_abort = '1; dbz_c1 = 1'bx;
    for (int c = 1; c <= LAST_C; c++) begin
      abort = (c == abort_cyc);
      if (c == 1) dbz_c1 = div_by_zero;
      if (c == abort_cyc + 1) snap_after_abort = out_vec();
      if (done) begin
        done_cnt++;
        if (done_first < 0) done_first = c;
      end
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (load_enable) begin
        load_cnt++;
        last_load = c;
      end
      if (q0_write) begin
        q0w_cnt++;
        q_bits = {q_bits[N-2:0], q0_value};
        if (q0_value) ones_cnt++;
      end
      if (restore_enable) restore_cnt++;
      if (load_enable || shift_left_enable_a || sub_enable || restore_enable || q0_write)
        dp_strobe_cnt++;
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_full(input string tag, input logic [N-1:0] dvd, input logic [N-1:0] dvs);
    logic [N-1:0] quot, rem;
    quot = dvd / dvs;
    rem  = dvd % dvs;
    check({tag, "_done_cycle"}, 32'(done_first), 32'(DONE_C));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_first"}, 32'(busy_first), 32'd1);
    check({tag, "_busy_last"}, 32'(busy_last), 32'(DONE_C - 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(DONE_C - 1));
    check({tag, "_q0_writes"}, 32'(q0w_cnt), 32'(N));
    check({tag, "_q_bits"}, 32'(q_bits), 32'(quot));
    check({tag, "_restores"}, 32'(restore_cnt), 32'(N - $countones(quot)));
    check({tag, "_dp_q"}, 32'(dp_q), 32'(quot));
    check({tag, "_dp_a"}, 32'(dp_a), 32'(rem));
  endtask

  initial begin
    logic [N-1:0] r_dvd, r_dvs;
    rst = 1'b1; start = 1'b0; abort = 1'b0; divisor = '0; dividend = '0;
    #2 rst = 1'b0;
    #2;
    check("reset_outputs", 32'(out_vec()), 32'd0);
    check("reset_iter", 32'(iter_count), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(16'd100, 16'd7, -1, 1'b0);
    check_full("d100_7", 16'd100, 16'd7);
    check("d100_7_q", 32'(dp_q), 32'd14);
    check("d100_7_a", 32'(dp_a), 32'd2);

    run_op(16'd55, 16'd0, -1, 1'b0);
    check("dz_done_cycle", 32'(done_first), 32'd1);
    check("dz_done_pulses", 32'(done_cnt), 32'd1);
    check("dz_busy_cycles", 32'(busy_cnt), 32'd0);
    check("dz_strobes", 32'(dp_strobe_cnt), 32'd0);
    check("dz_flag_c1", 32'(dbz_c1), 32'd1);
    check("dz_flag_sticky", 32'(div_by_zero), 32'd1);
    run_op(16'd10, 16'd3, -1, 1'b0);
    check("dz_clear_c1", 32'(dbz_c1), 32'd0);
    check_full("d10_3", 16'd10, 16'd3);

    run_op(16'hFFFF, 16'd1, -1, 1'b0);
    check_full("dffff_1", 16'hFFFF, 16'd1);
    check("dffff_1_ones", 32'(ones_cnt), 32'(N));
    check("dffff_1_restores", 32'(restore_cnt), 32'd0);
    run_op(16'd5, 16'd9, -1, 1'b0);
    check_full("d5_9", 16'd5, 16'd9);
    check("d5_9_ones", 32'(ones_cnt), 32'd0);
    check("d5_9_restores", 32'(restore_cnt), 32'(N));

    run_op(16'd1000, 16'd13, 20, 1'b0);
    check("abort_outputs_c21", 32'(snap_after_abort), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_busy_last", 32'(busy_last), 32'd20);
    run_op(16'd1000, 16'd13, -1, 1'b0);
    check_full("post_abort", 16'd1000, 16'd13);

    // abort and start together in IDLE: start must be ignored
    divisor = 16'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", 32'(out_vec()), 32'd0);
    @(negedge clk);

    // async reset during an iteration's SHIFT cycle (cycle 8, iter 2)
    dividend = 16'd300; divisor = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_shift", 32'(shift_left_enable_a), 32'd1);
    check("pre_reset_iter", 32'(iter_count), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs", 32'(out_vec()), 32'd0);
    check("async_reset_iter", 32'(iter_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    busy_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || load_enable) busy_cnt++;
    end
    check("post_reset_idle", 32'(busy_cnt), 32'd0);

    // start held high through DONE: re-accepted only from IDLE
    run_op(16'd777, 16'd11, -1, 1'b1);
    check("hold_done_cycle", 32'(done_first), 32'(DONE_C));
    check("hold_loads", 32'(load_cnt), 32'd2);
    check("hold_second_load", 32'(last_load), 32'(DONE_C + 2));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("hold_abort_idle", 32'(out_vec()), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      r_dvd = N'($urandom);
      r_dvs = N'($urandom) >> $urandom_range(0, N - 1);
      if (r_dvs == '0) r_dvs = N'(1);
      run_op(r_dvd, r_dvs, -1, 1'b0);
      check_full($sformatf("rand%0d", i), r_dvd, r_dvs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
